// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// uart_byte_tx : FIFO-buffered 8-bit LSB-first UART transmitter (8N1 default).
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
// Revision 1.0
// ============================================================================
module uart_byte_tx #(
  parameter int ClkFreq  = 50_000_000,
  parameter int BaudRate = 115200,
  parameter int FifoAw   = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] UARTSend,
  input  logic       UARTDatLock,
  output logic       UARTAvl,
  output logic       TxD,
  output logic       Busy,
  output logic       Overrun
);

  localparam int BaudDiv = ClkFreq / BaudRate;
  localparam int BaudW   = $clog2(BaudDiv);
  localparam int Depth   = 2 ** FifoAw;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BaudDiv - 1);
  localparam logic [FifoAw:0]  DepthCnt = (FifoAw + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop  = 3'd4
  } txState_t;

  logic              rLockD;
  logic [7:0]        rFifoMem [Depth];
  logic [FifoAw-1:0] rWrPtr, rRdPtr;
  logic [FifoAw:0]   rCount;
  logic              rOverrun;
  logic              wOffer, wRoom, wPush, wPop;
  logic [7:0]        wHeadByte;

  txState_t          rState, wStateNext;
  logic [BaudW-1:0]  rBaudCnt, wBaudNext;
  logic [2:0]        rBitCnt, wBitNext;
  logic [7:0]        rShift, wShiftNext;
  logic              rTxD, wTxDNext;
  logic              wBitEnd;
`ifdef UART_TX_PARITY_EN
  logic              rParity, wParityNext;
`endif

  // Acceptance is judged on the pre-cycle count, so a same-cycle pop never frees room for a push.
  assign wOffer    = UARTDatLock & ~rLockD;
  assign wRoom     = (rCount < DepthCnt);
  assign wPush     = wOffer & wRoom;
  assign wHeadByte = rFifoMem[rRdPtr];
  assign wBitEnd   = (rBaudCnt == BaudLast);

  assign UARTAvl = wRoom;
  assign TxD     = rTxD;
  assign Overrun = rOverrun;
  assign Busy    = (rState != StIdle) | (rCount != '0);

  always_ff @(posedge Clk) begin
    if (wPush) rFifoMem[rWrPtr] <= UARTSend;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rLockD   <= 1'b0;
      rWrPtr   <= '0;
      rRdPtr   <= '0;
      rCount   <= '0;
      rOverrun <= 1'b0;
    end else begin
      rLockD <= UARTDatLock;
      if (wPush) rWrPtr <= rWrPtr + 1'b1;
      if (wPop)  rRdPtr <= rRdPtr + 1'b1;
      case ({wPush, wPop})
        2'b10:   rCount <= rCount + 1'b1;
        2'b01:   rCount <= rCount - 1'b1;
        default: rCount <= rCount;
      endcase
      if (wOffer && !wRoom) rOverrun <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rState   <= StIdle;
      rBaudCnt <= '0;
      rBitCnt  <= '0;
      rShift   <= '0;
      rTxD     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      rParity  <= 1'b0;
`endif
    end else begin
      rState   <= wStateNext;
      rBaudCnt <= wBaudNext;
      rBitCnt  <= wBitNext;
      rShift   <= wShiftNext;
      rTxD     <= wTxDNext;
`ifdef UART_TX_PARITY_EN
      rParity  <= wParityNext;
`endif
    end
  end

  always_comb begin
    wStateNext = rState;
    wBaudNext  = rBaudCnt;
    wBitNext   = rBitCnt;
    wShiftNext = rShift;
    wPop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    wParityNext = rParity;
`endif
    if (rState != StIdle) wBaudNext = wBitEnd ? '0 : rBaudCnt + 1'b1;

    case (rState)
      StIdle: begin
        if (rCount != '0) begin
          wPop       = 1'b1;
          wShiftNext = wHeadByte;
          wBaudNext  = '0;
          wBitNext   = '0;
          wStateNext = StStart;
`ifdef UART_TX_PARITY_EN
          wParityNext = ^wHeadByte;
`endif
        end
      end
      StStart: if (wBitEnd) wStateNext = StData;
      StData: begin
        if (wBitEnd) begin
          wShiftNext = {1'b0, rShift[7:1]};
          wBitNext   = rBitCnt + 1'b1;
          if (rBitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            wStateNext = StParity;
`else
            wStateNext = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (wBitEnd) wStateNext = StStop;
`endif
      StStop: if (wBitEnd) wStateNext = StIdle;
      default: wStateNext = StIdle;
    endcase

    // Line level is registered from the next state so TxD is glitch-free.
    case (wStateNext)
      StStart:  wTxDNext = 1'b0;
      StData:   wTxDNext = wShiftNext[0];
`ifdef UART_TX_PARITY_EN
      StParity: wTxDNext = wParityNext;
`endif
      default:  wTxDNext = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// tb_uart_byte_tx : directed self-checking bench for uart_byte_tx (BaudDiv = 10).
module tb_uart_byte_tx;

`ifdef UART_TX_PARITY_EN
  localparam int Frame = 110;
`else
  localparam int Frame = 100;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [7:0] UARTSend = 8'h00;
  logic       UARTDatLock = 1'b0;
  logic       UARTAvl, TxD, Busy, Overrun;

  int checks = 0;
  int errors = 0;

  uart_byte_tx #(.ClkFreq(1_000_000), .BaudRate(100_000), .FifoAw(2)) dut (
    .Clk(Clk), .Rst(Rst), .UARTSend(UARTSend), .UARTDatLock(UARTDatLock),
    .UARTAvl(UARTAvl), .TxD(TxD), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitFall(input string tag, input int budget);
    int n = 0;
    while (TxD !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, TxD}, 32'd0);
  endtask

  // Entered on the first cycle TxD is low; returns at mid stop bit.
  task automatic checkFrame(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    step(5);
    chk($sformatf("start_%02h", v), {31'd0, TxD}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(10);
      chk($sformatf("data_%02h_b%0d", v, i), {31'd0, TxD}, {31'd0, v[i]});
    end
`ifdef UART_TX_PARITY_EN
    step(10);
    chk($sformatf("parity_%02h", v), {31'd0, TxD}, {31'd0, ^v});
`endif
    step(10);
    chk($sformatf("stop_%02h", v), {31'd0, TxD}, 32'd1);
  endtask

  task automatic pulse(input logic [7:0] b);
    UARTSend = b;
    UARTDatLock = 1'b1;
    step(1);
    UARTDatLock = 1'b0;
  endtask

  task automatic quietFor(input string tag, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (TxD !== 1'b1 || Busy !== 1'b0) lows++;
    end
    chk(tag, lows, 0);
  endtask

  logic [7:0] burst [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] ovf   [6] = '{8'hC1, 8'h82, 8'h43, 8'h24, 8'h99, 8'h66};

  initial begin
    step(3);
    Rst = 1'b1;

    // Reset and idle.
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("idle_outputs", {28'd0, TxD, UARTAvl, Busy, Overrun}, 32'b1100);
    end

    // Single offer 0xA5: falls at N+2, Busy drops Frame cycles after the fall.
    UARTSend = 8'hA5;
    UARTDatLock = 1'b1;
    step(1);
    UARTDatLock = 1'b0;
    chk("pre_fall", {31'd0, TxD}, 32'd1);
    step(1);
    chk("fall_n2", {31'd0, TxD}, 32'd0);
    checkFrame(8'hA5);
    step(4);
    chk("busy_last", {31'd0, Busy}, 32'd1);
    step(1);
    chk("busy_drop", {31'd0, Busy}, 32'd0);

    // Producer burst with UARTAvl flow control: contiguous frames, one idle clock between.
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int w = 0;
          while (UARTAvl !== 1'b1 && w < 500) begin step(1); w++; end
          pulse(burst[k]);
          step(1);
        end
      end
      begin
        waitFall("burst_fall", 20);
        for (int k = 0; k < 4; k++) begin
          checkFrame(burst[k]);
          if (k < 3) begin
            step(5);
            chk("b2b_idle", {31'd0, TxD}, 32'd1);
            step(1);
            chk("b2b_fall", {31'd0, TxD}, 32'd0);
          end
        end
      end
    join
    chk("burst_overrun", {31'd0, Overrun}, 32'd0);
    step(5);

    // Lock held high 30 cycles: exactly one frame.
    UARTSend = 8'h3C;
    UARTDatLock = 1'b1;
    step(2);
    chk("hold_fall", {31'd0, TxD}, 32'd0);
    fork
      begin step(28); UARTDatLock = 1'b0; end
      checkFrame(8'h3C);
    join
    step(5);
    quietFor("hold_one_frame", 40);

    // Overflow while a 0xFF frame is on the line.
    pulse(8'hFF);
    step(1);
    chk("lead_fall", {31'd0, TxD}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      UARTSend = ovf[k];
      UARTDatLock = 1'b1;
      step(1);
      UARTDatLock = 1'b0;
      if (k == 2) chk("avl_after_3", {31'd0, UARTAvl}, 32'd1);
      if (k == 3) chk("avl_after_4", {31'd0, UARTAvl}, 32'd0);
      if (k == 3) chk("ovr_after_4", {31'd0, Overrun}, 32'd0);
      if (k == 4) chk("ovr_after_5", {31'd0, Overrun}, 32'd1);
      step(1);
    end
    waitFall("ovf_fall", 200);
    for (int k = 0; k < 4; k++) begin
      checkFrame(ovf[k]);
      if (k < 3) begin
        step(5);
        chk("ovf_b2b_idle", {31'd0, TxD}, 32'd1);
        step(1);
        chk("ovf_b2b_fall", {31'd0, TxD}, 32'd0);
      end
    end
    step(5);
    quietFor("ovf_only_four", 40);
    chk("ovr_sticky", {31'd0, Overrun}, 32'd1);

    // 0x07 frame (parity bit 1 when enabled), then reset mid third data bit.
    pulse(8'h07);
    step(1);
    chk("p07_fall", {31'd0, TxD}, 32'd0);
    checkFrame(8'h07);
    step(5);
    pulse(8'h07);
    step(1);
    chk("rst_frame_fall", {31'd0, TxD}, 32'd0);
    pulse(8'h5A);
    step(33);
    chk("rst_mid_bit2", {31'd0, TxD}, 32'd1);
    Rst = 1'b0;
    #1;
    chk("rst_txd", {31'd0, TxD}, 32'd1);
    chk("rst_flags", {29'd0, UARTAvl, Busy, Overrun}, 32'b100);
    step(1);
    Rst = 1'b1;
    quietFor("no_frame_after_rst", 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_byte_tx.md
# uart_byte_tx

Byte-serial UART transmitter that consumes the lock/available byte handshake driven by the measurement-result senders (demodulation readout, state replies). It captures each offered byte into a small FIFO and shifts it out on `TxD` as an 8-bit, LSB-first frame at a fixed baud rate. It sits between the command/readout logic and the FPGA UART TX pin.

## Interface
Parameters:
- `ClkFreq`, 50_000_000, system clock frequency in Hz
- `BaudRate`, 115200, line rate in bit/s; `BaudDiv = ClkFreq / BaudRate` (truncating), must be ≥ 2
- `FifoAw`, 2, FIFO address width; depth = 2^FifoAw (default 4 bytes)

Ports:
- `Clk` input 1: system clock; all logic on rising edge
- `Rst` input 1: asynchronous, active-low reset
- `UARTSend` input 8: byte offered by the producer
- `UARTDatLock` input 1: producer strobe; a rising edge offers `UARTSend`
- `UARTAvl` output 1: high when the FIFO can accept a byte
- `TxD` output 1: serial line, idle high
- `Busy` output 1: high while a frame is on the line or the FIFO is non-empty
- `Overrun` output 1: sticky; set when a byte is offered while the FIFO is full

## Operation
- Reset values: `TxD`=1, `UARTAvl`=1, `Busy`=0, `Overrun`=0, FIFO empty, TX FSM in IDLE, baud and bit counters 0.
- Offer detection: `UARTDatLock` is registered once (`LockD`). An offer is `UARTDatLock & ~LockD`. `UARTSend` is sampled in the same cycle. A level held high offers only one byte.
- Accept rule: an offer is written if the FIFO count before the edge is < depth. Otherwise the byte is discarded and `Overrun` is set. `Overrun` clears only on reset.
- `UARTAvl` = (count < depth), driven from the registered count.
- Simultaneous push and pop: both take effect and the count is unchanged. Push acceptance is still judged on the pre-cycle count, so a full FIFO rejects even if a pop occurs in the same cycle.
- TX FSM states:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: `TxD`=0 for `BaudDiv` cycles, then go to DATA.
  - DATA: drive `shift[0]` for `BaudDiv` cycles, then shift right. After 8 bits go to PARITY (if enabled) or STOP.
  - PARITY: drive the even-parity bit (XOR of the 8 data bits) for `BaudDiv` cycles.
  - STOP: `TxD`=1 for `BaudDiv` cycles, then return to IDLE.
- Back-to-back frames: IDLE pops in the cycle it is entered, so there is no idle gap beyond one clock between frames.
- `Busy` = (state != IDLE) | (count != 0).
- Reset mid-frame: the frame is aborted, `TxD` returns to 1 asynchronously, and the FIFO is flushed.

## Timing
- Offer seen in cycle N: the FIFO write happens at the end of N. IDLE pops at the end of N+1. `TxD` falls at the start of cycle N+2.
- Each bit lasts exactly `BaudDiv` clocks. A frame lasts 10·`BaudDiv` clocks (11·`BaudDiv` with parity).
- `UARTAvl` falls in the cycle after the write that fills the FIFO. It rises in the cycle after the pop that frees a slot.
- Baud counter range is 0..`BaudDiv`-1 and it reloads at each bit boundary with no drift across frames.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is present, giving an 11-bit frame with an even-parity bit between data and stop.
- `UART_TX_PARITY_EN` undefined: the PARITY state is absent and the frame is 10 bits (8N1).

## Test plan
Bench settings: `ClkFreq`=1_000_000, `BaudRate`=100_000 (`BaudDiv`=10), no parity unless stated.
- Reset then idle 50 cycles -> `TxD`=1, `UARTAvl`=1, `Busy`=0, `Overrun`=0 throughout.
- Single offer 0xA5 with a 1-cycle lock pulse at cycle N -> `TxD` falls at N+2. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1,1. `Busy` drops 100 cycles after the fall.
- Producer-style burst of the 32-bit word 0x12345678 (MSB byte first, lock raised only while `UARTAvl`=1) -> four contiguous frames 0x12, 0x34, 0x56, 0x78, with ≤1 idle clock between frames and `Overrun`=0.
- Six offers on consecutive edges ignoring `UARTAvl` -> four bytes transmitted, `UARTAvl`=0 after the 4th write, `Overrun`=1 after the 5th.
- Lock held high for 30 cycles with 0x3C -> exactly one frame transmitted.
- With `UART_TX_PARITY_EN`: offer 0x07 -> 11-bit frame with parity bit 1. Assert `Rst` low in the middle of the 3rd data bit -> `TxD`=1 immediately, FIFO empty, and no frame after reset release.
